// File: rtl/tap_pkg.sv
// Shared TAP types and constants.
//  tap_state_t        : 16 TAP states, IEEE 1149.1 encoding
//  IR_CAPTURE_PATTERN : value loaded into the IR shift register at CAPTURE_IR
//  BYPASS_OPCODE      : all-ones instruction selecting the 1-bit bypass DR
package tap_pkg;

    localparam int unsigned TAP_IR_WIDTH = 6;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [TAP_IR_WIDTH-1:0] IR_CAPTURE_PATTERN = TAP_IR_WIDTH'(2'b01);
    localparam logic [TAP_IR_WIDTH-1:0] BYPASS_OPCODE      = '1;

endpackage

// File: rtl/tap_fsm.sv
// TAP state sequencer: state register plus 1149.1 next-state logic.
//  tck    in  : JTAG clock
//  trst_n in  : synchronous active-low reset to TEST_LOGIC_RESET
//  tms    in  : mode select steering the state graph
//  state  out : current TAP state (registered)
module tap_fsm
    import tap_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state
);

    tap_state_t r_state;
    tap_state_t w_next;

    // State register; reset has priority over tms.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Standard 1149.1 transition graph.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            TEST_LOGIC_RESET: w_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    w_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   w_next = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       w_next = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         w_next = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         w_next = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         w_next = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         w_next = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        w_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   w_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       w_next = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         w_next = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         w_next = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         w_next = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         w_next = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        w_next = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          w_next = TEST_LOGIC_RESET;
        endcase
    end

    assign state = r_state;

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: FSM, instruction register, IDCODE/BYPASS DRs, tdo mux.
//  tck, trst_n       in  : JTAG clock, synchronous active-low reset
//  tms, tdi          in  : mode select, serial data in
//  user_tdo          in  : serial return from the user DR
//  tdo               out : serial data out (combinational mux)
//  test_logic_reset,
//  run_test_idle,
//  capture_dr,
//  shift_dr,
//  update_dr         out : Moore decodes of the TAP state
//  ir_is_user        out : latched instruction selects the user DR
//  ir                out : latched instruction
module tap_controller
    import tap_pkg::*;
#(
    parameter int unsigned           IR_WIDTH      = TAP_IR_WIDTH,
    parameter logic [IR_WIDTH-1:0]   USER_OPCODE   = IR_WIDTH'(6'h02),
    parameter logic [IR_WIDTH-1:0]   IDCODE_OPCODE = IR_WIDTH'(6'h09),
    parameter logic [31:0]           IDCODE_VALUE  = 32'h0000_0001
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                tms,
    input  logic                tdi,
    input  logic                user_tdo,
    output logic                tdo,
    output logic                test_logic_reset,
    output logic                run_test_idle,
    output logic                ir_is_user,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic [IR_WIDTH-1:0] ir
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_PATTERN);

    tap_state_t          w_state;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [31:0]         r_idcode_shift;
    logic                r_bypass;

    tap_fsm u_fsm (
        .tck    (tck),
        .trst_n (trst_n),
        .tms    (tms),
        .state  (w_state)
    );

    // Instruction register: shift path plus latched instruction.
    // TLR keeps forcing IDCODE so ir only ever changes at UPDATE_IR or reset.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            r_ir       <= IDCODE_OPCODE;
            r_ir_shift <= '0;
        end else begin
            if (w_state == TEST_LOGIC_RESET) begin
                r_ir <= IDCODE_OPCODE;
            end else if (w_state == UPDATE_IR) begin
                r_ir <= r_ir_shift;
            end
            if (w_state == CAPTURE_IR) begin
                r_ir_shift <= IR_CAPTURE;
            end else if (w_state == SHIFT_IR) begin
                r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
            end
        end
    end

    // IDCODE and BYPASS data registers; both capture and shift on every DR scan.
    always_ff @(posedge tck) begin
        if (!trst_n) begin
            r_idcode_shift <= '0;
            r_bypass       <= 1'b0;
        end else if (w_state == CAPTURE_DR) begin
            r_idcode_shift <= IDCODE_VALUE;
            r_bypass       <= 1'b0;
        end else if (w_state == SHIFT_DR) begin
            r_idcode_shift <= {tdi, r_idcode_shift[31:1]};
            r_bypass       <= tdi;
        end
    end

    // Return mux; any opcode other than user/IDCODE behaves as BYPASS.
    always_comb begin
        tdo = 1'b0;
        if (w_state == SHIFT_IR) begin
            tdo = r_ir_shift[0];
        end else if (w_state == SHIFT_DR) begin
            if (r_ir == USER_OPCODE) begin
                tdo = user_tdo;
            end else if (r_ir == IDCODE_OPCODE) begin
                tdo = r_idcode_shift[0];
            end else begin
                tdo = r_bypass;
            end
        end
    end

    assign test_logic_reset = (w_state == TEST_LOGIC_RESET);
    assign run_test_idle    = (w_state == RUN_TEST_IDLE);
    assign capture_dr       = (w_state == CAPTURE_DR);
    assign shift_dr         = (w_state == SHIFT_DR);
    assign update_dr        = (w_state == UPDATE_DR);
    assign ir_is_user       = (r_ir == USER_OPCODE);
    assign ir               = r_ir;

endmodule
